// File: rtl/mpc_qp_admm_vec_ram_1r1w_p_if.sv
// mpc_qp_admm_vec_ram_1r1w_p_if
// Bundles the port 0 read/write and port 1 read-only signals of the ADMM
// vector RAM together with the clear handshake.
//   master : drives addresses, enables, write data and the clear pulse
//   slave  : the RAM itself; returns q0/q1, their valid strobes and busy
interface mpc_qp_admm_vec_ram_1r1w_p_if #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 5
);
  logic [AddressWidth-1:0]  address0;
  logic                     ce0;
  logic                     we0;
  logic [DataWidth/8-1:0]   be0;
  logic [DataWidth-1:0]     d0;
  logic [DataWidth-1:0]     q0;
  logic                     q0_vld;
  logic [AddressWidth-1:0]  address1;
  logic                     ce1;
  logic [DataWidth-1:0]     q1;
  logic                     q1_vld;
  logic                     clear;
  logic                     busy;

  modport master (
    output address0, ce0, we0, be0, d0, address1, ce1, clear,
    input  q0, q0_vld, q1, q1_vld, busy
  );

  modport slave (
    input  address0, ce0, we0, be0, d0, address1, ce1, clear,
    output q0, q0_vld, q1, q1_vld, busy
  );
endinterface

// File: rtl/mpc_qp_admm_vec_ram_1r1w_p.sv
// mpc_qp_admm_vec_ram_1r1w_p
// Parametrised 1R1W vector RAM for the ADMM QP solver datapath.
// Port 0 reads and byte-writes, port 1 only reads. Both read paths have a
// ReadLatency-deep pipeline with a valid strobe; q holds its last value.
// A clear sequencer rewrites every word with InitValue between iterations.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : slave modport of mpc_qp_admm_vec_ram_1r1w_p_if
//            (address0/ce0/we0/be0/d0/q0/q0_vld, address1/ce1/q1/q1_vld,
//             clear, busy)
//
// Optional feature macro: MPC_RAM_RESET_CLEAR_EN
//   When defined, releasing reset automatically runs a full clear sequence.
module mpc_qp_admm_vec_ram_1r1w_p #(
  parameter int                   DataWidth    = 32,
  parameter int                   AddressWidth = 5,
  parameter int                   AddressRange = 24,
  parameter int                   ReadLatency  = 1,
  parameter int                   WriteMode    = 0,
  parameter logic [DataWidth-1:0] InitValue    = '0
) (
  input logic clk,
  input logic reset,
  mpc_qp_admm_vec_ram_1r1w_p_if.slave bus
);

  localparam int NumBytes = DataWidth / 8;
  localparam logic [AddressWidth:0]   RangeLimit  = (AddressWidth + 1)'(AddressRange);
  localparam logic [AddressWidth-1:0] LastAddress = AddressWidth'(AddressRange - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state, stateNext;
  logic [AddressWidth-1:0] clearAddr, clearAddrNext;
  logic                    clearing;

  logic [DataWidth-1:0] mem [AddressRange];

  logic                 inRange0, inRange1;
  logic                 rdIssue [2];
  logic                 wrEn0;
  logic                 collision1;
  logic [DataWidth-1:0] oldWord0, oldWord1, mergedWord0;
  logic [DataWidth-1:0] rdData [2];

  logic [DataWidth-1:0]   pipeData [2][ReadLatency];
  logic [ReadLatency-1:0] pipeVld  [2];

`ifdef MPC_RAM_RESET_CLEAR_EN
  // Remembers that reset was just held; the first cycle after it falls acts
  // as CLEAR at address 0 so busy rises immediately on reset release.
  logic initPending;

  always_ff @(posedge clk) begin
    initPending <= reset;
  end

  assign clearing = (state == CLEAR) || (initPending && !reset);
`else
  assign clearing = (state == CLEAR);
`endif

  assign bus.busy = clearing;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      clearAddr <= '0;
    end else begin
      state     <= stateNext;
      clearAddr <= clearAddrNext;
    end
  end

  // A clear request while already clearing is simply ignored.
  always_comb begin
    stateNext     = state;
    clearAddrNext = clearAddr;
    if (clearing) begin
      if (clearAddr == LastAddress) begin
        stateNext     = IDLE;
        clearAddrNext = '0;
      end else begin
        stateNext     = CLEAR;
        clearAddrNext = clearAddr + AddressWidth'(1);
      end
    end else if (bus.clear) begin
      stateNext     = CLEAR;
      clearAddrNext = '0;
    end
  end

  // Out-of-range addresses read as zero and never write.
  assign inRange0   = {1'b0, bus.address0} < RangeLimit;
  assign inRange1   = {1'b0, bus.address1} < RangeLimit;
  assign rdIssue[0] = bus.ce0 && !clearing;
  assign rdIssue[1] = bus.ce1 && !clearing;
  assign wrEn0      = rdIssue[0] && bus.we0 && inRange0;
  assign oldWord0   = inRange0 ? mem[bus.address0] : '0;
  assign oldWord1   = inRange1 ? mem[bus.address1] : '0;
  assign collision1 = wrEn0 && inRange1 && (bus.address1 == bus.address0);

  // Word as it will look after this cycle's byte-enabled write; used for
  // write-first reads on either port.
  always_comb begin
    mergedWord0 = oldWord0;
    for (int i = 0; i < NumBytes; i++) begin
      if (wrEn0 && bus.be0[i]) begin
        mergedWord0[8*i +: 8] = bus.d0[8*i +: 8];
      end
    end
  end

  assign rdData[0] = (WriteMode == 1) ? mergedWord0 : oldWord0;
  assign rdData[1] = (WriteMode == 1 && collision1) ? mergedWord0 : oldWord1;

  // Clear writes are blocked on a reset edge so an aborted clear stops at the
  // last word it fully committed before reset.
  always_ff @(posedge clk) begin
    if (clearing && !reset) begin
      mem[clearAddr] <= InitValue;
    end else if (wrEn0) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (bus.be0[i]) begin
          mem[bus.address0][8*i +: 8] <= bus.d0[8*i +: 8];
        end
      end
    end
  end

  // Each stage only loads when valid data moves into it, so the last stage
  // (which drives q) holds the most recent read between accesses.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        pipeVld[p] <= '0;
        for (int k = 0; k < ReadLatency; k++) begin
          pipeData[p][k] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        pipeVld[p][0] <= rdIssue[p];
        if (rdIssue[p]) begin
          pipeData[p][0] <= rdData[p];
        end
        for (int k = 1; k < ReadLatency; k++) begin
          pipeVld[p][k] <= pipeVld[p][k-1];
          if (pipeVld[p][k-1]) begin
            pipeData[p][k] <= pipeData[p][k-1];
          end
        end
      end
    end
  end

  assign bus.q0     = pipeData[0][ReadLatency-1];
  assign bus.q0_vld = pipeVld[0][ReadLatency-1];
  assign bus.q1     = pipeData[1][ReadLatency-1];
  assign bus.q1_vld = pipeVld[1][ReadLatency-1];

endmodule

// File: tb/tb_mpc_qp_admm_vec_ram_1r1w_p.sv
// tb_mpc_qp_admm_vec_ram_1r1w_p
// Drives two RAM instances with identical stimulus:
//   instA : WriteMode=0, ReadLatency=1, InitValue=0xDEADBEEF
//   instB : WriteMode=1, ReadLatency=3, InitValue=0x0BADF00D
// and compares every cycle against a behavioural word-array model.
// Honors MPC_RAM_RESET_CLEAR_EN when the build defines it.
module tb_mpc_qp_admm_vec_ram_1r1w_p;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int AR = 24;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mpc_qp_admm_vec_ram_1r1w_p_if #(.DataWidth(DW), .AddressWidth(AW)) busA ();
  mpc_qp_admm_vec_ram_1r1w_p_if #(.DataWidth(DW), .AddressWidth(AW)) busB ();

  mpc_qp_admm_vec_ram_1r1w_p #(
    .DataWidth(DW), .AddressWidth(AW), .AddressRange(AR),
    .ReadLatency(1), .WriteMode(0), .InitValue(32'hDEADBEEF)
  ) instA (
    .clk(clk), .reset(reset), .bus(busA)
  );

  mpc_qp_admm_vec_ram_1r1w_p #(
    .DataWidth(DW), .AddressWidth(AW), .AddressRange(AR),
    .ReadLatency(3), .WriteMode(1), .InitValue(32'h0BADF00D)
  ) instB (
    .clk(clk), .reset(reset), .bus(busB)
  );

  int modelWM [2];
  int modelRL [2];
  logic [31:0] modelInit [2];
  logic [31:0] modelMem [2][AR];
  bit modelBusy [2];
  int modelClrAddr [2];
  bit expVld [2][2][8];
  logic [31:0] expData [2][2][8];
  logic [31:0] lastQ [2][2];
  bit initPend = 1'b0;

  int sAddr0, sAddr1;
  bit sCe0, sWe0, sCe1, sClear, sReset;
  logic [3:0] sBe0;
  logic [31:0] sD0;

  int cycle = 0;
  int total = 0;
  int bad = 0;
  bit countBusy = 1'b0;
  int busyCnt = 0;

  task automatic applyStimulus(input bit rst, input int a0, input bit c0, input bit w0,
                               input logic [3:0] b0, input logic [31:0] d,
                               input int a1, input bit c1, input bit clr);
    sReset = rst; sAddr0 = a0; sCe0 = c0; sWe0 = w0; sBe0 = b0; sD0 = d;
    sAddr1 = a1; sCe1 = c1; sClear = clr;
    reset = rst;
    busA.address0 = AW'(a0); busA.ce0 = c0; busA.we0 = w0; busA.be0 = b0; busA.d0 = d;
    busA.address1 = AW'(a1); busA.ce1 = c1; busA.clear = clr;
    busB.address0 = AW'(a0); busB.ce0 = c0; busB.we0 = w0; busB.be0 = b0; busB.d0 = d;
    busB.address1 = AW'(a1); busB.ce1 = c1; busB.clear = clr;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 4'h0, 32'h0, 0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rdMem(input int d, input int a);
    return (a < AR) ? modelMem[d][a] : 32'h0;
  endfunction

  function automatic bit expBusy(input int d);
`ifdef MPC_RAM_RESET_CLEAR_EN
    return modelBusy[d] || (initPend && !sReset);
`else
    return modelBusy[d];
`endif
  endfunction

  // Applies one clock edge worth of behaviour to the model.
  task automatic modelEdge();
    logic [31:0] old0, old1, new0, new1;
    bit active;
    int slot;
    for (int d = 0; d < 2; d++) begin
      if (sReset) begin
        modelBusy[d] = 1'b0;
        for (int p = 0; p < 2; p++) begin
          lastQ[d][p] = 32'h0;
          for (int s = 0; s < 8; s++) expVld[d][p][s] = 1'b0;
        end
      end else begin
        active = modelBusy[d];
`ifdef MPC_RAM_RESET_CLEAR_EN
        if (initPend) begin
          active = 1'b1;
          modelClrAddr[d] = 0;
        end
`endif
        if (active) begin
          modelMem[d][modelClrAddr[d]] = modelInit[d];
          modelClrAddr[d]++;
          modelBusy[d] = (modelClrAddr[d] < AR);
        end else begin
          old0 = rdMem(d, sAddr0);
          old1 = rdMem(d, sAddr1);
          if (sCe0 && sWe0 && sAddr0 < AR) begin
            for (int i = 0; i < 4; i++) begin
              if (sBe0[i]) modelMem[d][sAddr0][8*i +: 8] = sD0[8*i +: 8];
            end
          end
          new0 = rdMem(d, sAddr0);
          new1 = rdMem(d, sAddr1);
          slot = (cycle + modelRL[d] - 1) % 8;
          if (sCe0) begin
            expVld[d][0][slot]  = 1'b1;
            expData[d][0][slot] = (modelWM[d] == 1) ? new0 : old0;
          end
          if (sCe1) begin
            expVld[d][1][slot]  = 1'b1;
            expData[d][1][slot] = (modelWM[d] == 1) ? new1 : old1;
          end
          if (sClear) begin
            modelBusy[d] = 1'b1;
            modelClrAddr[d] = 0;
          end
        end
      end
    end
`ifdef MPC_RAM_RESET_CLEAR_EN
    initPend = sReset;
`endif
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    logic [31:0] actQ [2][2];
    logic actV [2][2];
    logic actBusy [2];
    logic [31:0] eq;
    bit ev;
    int s;
    actQ[0][0] = busA.q0; actV[0][0] = busA.q0_vld;
    actQ[0][1] = busA.q1; actV[0][1] = busA.q1_vld;
    actQ[1][0] = busB.q0; actV[1][0] = busB.q0_vld;
    actQ[1][1] = busB.q1; actV[1][1] = busB.q1_vld;
    actBusy[0] = busA.busy; actBusy[1] = busB.busy;
    s = cycle % 8;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (expVld[d][p][s]) begin
          ev = 1'b1;
          eq = expData[d][p][s];
          lastQ[d][p] = eq;
          expVld[d][p][s] = 1'b0;
        end else begin
          ev = 1'b0;
          eq = lastQ[d][p];
        end
        total++;
        assert (actV[d][p] === ev) else begin
          bad++;
          $error("[TB] FAIL vld dut%0d port%0d cycle=%0d observed=%b expected=%b", d, p, cycle, actV[d][p], ev);
        end
        total++;
        assert (actQ[d][p] === eq) else begin
          bad++;
          $error("[TB] FAIL q dut%0d port%0d cycle=%0d observed=%h expected=%h", d, p, cycle, actQ[d][p], eq);
        end
      end
      total++;
      assert (actBusy[d] === expBusy(d)) else begin
        bad++;
        $error("[TB] FAIL busy dut%0d cycle=%0d observed=%b expected=%b", d, cycle, actBusy[d], expBusy(d));
      end
    end
  endtask

  // Busy is sampled mid-cycle so the combinational rise after reset release
  // is counted as well.
  task automatic tick();
    #2;
    if (countBusy && busA.busy === 1'b1) busyCnt++;
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput();
    cycle++;
  endtask

  initial begin
    modelWM[0] = 0; modelRL[0] = 1; modelInit[0] = 32'hDEADBEEF;
    modelWM[1] = 1; modelRL[1] = 3; modelInit[1] = 32'h0BADF00D;
    for (int d = 0; d < 2; d++) begin
      modelBusy[d] = 1'b0;
      modelClrAddr[d] = 0;
      for (int p = 0; p < 2; p++) for (int s = 0; s < 8; s++) expVld[d][p][s] = 1'b0;
    end
    $display("[TB] start");

    // Reset: all outputs zero.
    applyStimulus(1'b1, 0, 1'b0, 1'b0, 4'h0, 32'h0, 0, 1'b0, 1'b0);
    tick();
    tick();
    checkValue("reset_q0", busA.q0, 32'h0);
    checkValue("reset_busy", {31'h0, busA.busy}, 32'h0);

    // Clear with both ports requesting throughout; defines all memory.
    countBusy = 1'b1;
    idle();
    tick();
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 4'h0, 32'h0, 0, 1'b0, 1'b1);
    tick();
    for (int n = 0; n < 30; n++) begin
      applyStimulus(1'b0, $urandom_range(0, 31), 1'b1, $urandom_range(0, 1),
                    4'($urandom), $urandom, $urandom_range(0, 31), 1'b1, 1'b0);
      tick();
    end
    countBusy = 1'b0;
    checkValue("clear_busy_cycles", busyCnt, AR);
    idle();
    for (int n = 0; n < 3; n++) tick();
    for (int a = 0; a < AR; a++) begin
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 4'h0, 32'h0, a, 1'b1, 1'b0);
      tick();
    end
    idle();
    for (int n = 0; n < 3; n++) tick();

    // Write then read address 3.
    applyStimulus(1'b0, 3, 1'b1, 1'b1, 4'hF, 32'h12345678, 0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 4'h0, 32'h0, 3, 1'b1, 1'b0);
    tick();
    checkValue("rd3_q1_A", busA.q1, 32'h12345678);
    checkValue("rd3_vld_A", {31'h0, busA.q1_vld}, 32'h1);
    idle();
    tick();
    tick();
    checkValue("rd3_q1_B", busB.q1, 32'h12345678);

    // Same-cycle collision at address 5.
    applyStimulus(1'b0, 5, 1'b1, 1'b1, 4'hF, 32'hAAAAAAAA, 0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 5, 1'b1, 1'b1, 4'h3, 32'h55555555, 5, 1'b1, 1'b0);
    tick();
    checkValue("coll_q1_A", busA.q1, 32'hAAAAAAAA);
    checkValue("coll_q0_A", busA.q0, 32'hAAAAAAAA);
    idle();
    tick();
    tick();
    checkValue("coll_q1_B", busB.q1, 32'hAAAA5555);
    checkValue("coll_q0_B", busB.q0, 32'hAAAA5555);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 4'h0, 32'h0, 5, 1'b1, 1'b0);
    tick();
    checkValue("after_coll_A", busA.q1, 32'hAAAA5555);
    idle();
    tick();
    tick();
    checkValue("after_coll_B", busB.q1, 32'hAAAA5555);

    // Back-to-back reads of 0,1,2.
    for (int a = 0; a < 3; a++) begin
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 4'h0, 32'h0, a, 1'b1, 1'b0);
      tick();
    end
    idle();
    for (int n = 0; n < 4; n++) tick();

    // Out-of-range read and write at address 30.
    applyStimulus(1'b0, 30, 1'b1, 1'b0, 4'h0, 32'h0, 0, 1'b0, 1'b0);
    tick();
    checkValue("oor_q0_A", busA.q0, 32'h0);
    checkValue("oor_vld_A", {31'h0, busA.q0_vld}, 32'h1);
    applyStimulus(1'b0, 30, 1'b1, 1'b1, 4'hF, 32'hCAFEF00D, 0, 1'b0, 1'b0);
    tick();
    for (int a = 0; a < AR; a++) begin
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 4'h0, 32'h0, a, 1'b1, 1'b0);
      tick();
    end
    idle();
    for (int n = 0; n < 3; n++) tick();

    // Randomised traffic with occasional clears.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'b0, $urandom_range(0, 31), $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                    4'($urandom), $urandom, $urandom_range(0, 31), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 49) == 0);
      tick();
    end
    idle();
    for (int n = 0; n < 30; n++) tick();

    // Reset ten cycles into a clear.
    for (int a = 0; a < AR; a++) begin
      applyStimulus(1'b0, a, 1'b1, 1'b1, 4'hF, $urandom, 0, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 4'h0, 32'h0, 0, 1'b0, 1'b1);
    tick();
    idle();
    for (int n = 0; n < 10; n++) tick();
    applyStimulus(1'b1, 0, 1'b0, 1'b0, 4'h0, 32'h0, 0, 1'b0, 1'b0);
    tick();
    checkValue("abort_busy", {31'h0, busA.busy}, 32'h0);
    checkValue("abort_q1", busA.q1, 32'h0);
    idle();
    tick();
    for (int n = 0; n < 26; n++) tick();
    for (int a = 0; a < AR; a++) begin
      applyStimulus(1'b0, AR - 1 - a, 1'b1, 1'b0, 4'h0, 32'h0, a, 1'b1, 1'b0);
      tick();
    end
    idle();
    for (int n = 0; n < 4; n++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mpc_qp_admm_vec_ram_1r1w_p.md
# mpc_qp_admm_vec_ram_1r1w_p

Parametrised 1R1W vector RAM for the ADMM QP solver datapath: port 0 reads/writes, port 1 reads only. It generalises the fixed single-cycle vector buffers with:
- configurable read latency and collision mode;
- per-byte write enables and read-valid strobes;
- an on-demand clear sequencer that reinitialises the vector between solver iterations.

## Interface
Parameters:
- DataWidth, 32, word width in bits; must be a multiple of 8.
- AddressWidth, 5, address bus width.
- AddressRange, 24, number of words; must be ≤ 2^AddressWidth.
- ReadLatency, 1, read pipeline depth in cycles; legal range 1..3.
- WriteMode, 0, collision behaviour:
  - 0 = read-first (old data);
  - 1 = write-first (new data).
- InitValue, 0, word written by the clear sequencer.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- address0  in  AddressWidth  port 0 address.
- ce0  in  1  port 0 enable.
- we0  in  1  port 0 write enable; qualified by ce0.
- be0  in  DataWidth/8  port 0 byte enables; qualified by we0.
- d0  in  DataWidth  port 0 write data.
- q0  out  DataWidth  port 0 read data.
- q0_vld  out  1  port 0 read data valid; one-cycle pulse.
- address1  in  AddressWidth  port 1 address.
- ce1  in  1  port 1 read enable.
- q1  out  DataWidth  port 1 read data.
- q1_vld  out  1  port 1 read data valid; one-cycle pulse.
- clear  in  1  start clear sequence; single-cycle pulse.
- busy  out  1  clear sequence in progress.

## Operation
- Port 0 access (ce0=1, busy=0):
  - Writes bytes where we0 & be0[i].
  - Issues a read in the same cycle.
  - Read data is pre-write (WriteMode=0) or post-write merged word (WriteMode=1).
- Port 1 read (ce1=1, busy=0): issues a read of address1.
- Port 0 write and port 1 read to the same address in the same cycle: q1 follows WriteMode (old word, or byte-merged new word).
- Address ≥ AddressRange:
  - writes are dropped;
  - reads return 0, with vld asserted normally.
- Clear FSM states: IDLE, CLEAR.
  - IDLE→CLEAR on clear=1; counter loads 0.
  - In CLEAR, writes InitValue to address counter, one word per cycle, all bytes.
  - CLEAR→IDLE after writing address AddressRange-1.
  - busy=1 exactly while in CLEAR, which lasts AddressRange cycles.
  - clear while busy=1 is ignored.
- While busy=1:
  - ce0/ce1 are masked: no writes, no reads issued, no vld pulses for those cycles.
  - Reads already in the pipeline complete normally.
- Memory contents are not affected by reset unless the Configuration macro is enabled.

## Timing
- Read issued at edge t appears on q at edge t+ReadLatency, with vld high for that one cycle.
- q holds its last value between reads; vld=0 otherwise.
- Pipeline advances every cycle (no stall input); back-to-back reads give back-to-back vld.
- Write committed at edge t is visible to any read issued at edge t+1 or later.
- Reset values: q0=0, q1=0, q0_vld=0, q1_vld=0, busy=0, FSM=IDLE, pipeline flushed.
- Reset asserted mid-clear aborts the clear:
  - busy=0 on the next cycle;
  - words already written keep InitValue.
- clear and ce0 in the same cycle while IDLE: the port 0 access executes, CLEAR starts next cycle, and the clear overwrites it.

## Configuration
- MPC_RAM_RESET_CLEAR_EN:
  - Defined: deasserting reset automatically enters CLEAR. busy=1 from the first cycle after reset falls, for AddressRange cycles, so the RAM holds InitValue before first use.
  - Undefined: reset leaves the RAM contents untouched, and CLEAR is entered only via clear.

## Test plan
- Defaults, WriteMode=0. Write address0=3, d0=0x12345678, be0=0xF. Then ce1 read of address 3. Required: q1=0x12345678 with q1_vld one cycle after the read.
- Same-cycle collision at address 5 (old 0xAAAAAAAA, new 0x55555555, be0=0x3):
  - WriteMode=0 → q1=0xAAAAAAAA;
  - WriteMode=1 → q1=0xAAAA5555;
  - later read of address 5 = 0xAAAA5555 in both modes.
- ReadLatency=3, reads of addresses 0,1,2 on consecutive cycles. Required: vld high on 3 consecutive cycles starting 3 cycles after the first read, data in order.
- InitValue=0xDEADBEEF, pulse clear, assert ce0/ce1 throughout. Required:
  - busy high for 24 cycles, no vld during busy;
  - afterwards all 24 addresses read 0xDEADBEEF.
- Reset after 10 cycles of CLEAR. Required:
  - busy=0 and outputs 0 next cycle;
  - addresses 0..9 read InitValue, addresses 10..23 keep prior data.
- Read of address 30 (out of range) and write to address 30. Required: q0=0, q0_vld pulses, addresses 0..23 unchanged. With MPC_RAM_RESET_CLEAR_EN, reset release → busy for 24 cycles.
